echo_delay_unit: RTL

Downstream stage of the FIR filter. It takes each filtered 16-bit signed sample and adds a feedback echo read from a circular delay line, giving y[n] = x[n] + g*y[n-D]. The result is saturated, written back into the delay line and presented to the output/codec stage. One sample is processed per in_valid strobe, using a fixed multi-cycle FSM.

---
 rtl/echo_delay_unit_pkg.sv | 24 ++
 rtl/echo_delay_unit_ram.sv | 21 ++
 rtl/echo_delay_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/echo_delay_unit_pkg.sv
// Shared definitions for the echo delay unit: widths, saturation limits,
// FSM state encoding and the output saturator.
package echo_pkg;

  localparam int DATA_W  = 16;
  localparam int GAIN_W  = 8;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  localparam logic [2:0] CLR  = 3'd0;
  localparam logic [2:0] IDLE = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] MIX  = 3'd4;
  localparam logic [2:0] WR   = 3'd5;

  // Clamp the 18-bit mix sum into the 16-bit sample range.
  function automatic logic signed [15:0] saturate(input logic signed [17:0] s);
    if (s > 18'(SAT_MAX))      return 16'(SAT_MAX);
    else if (s < 18'(SAT_MIN)) return 16'(SAT_MIN);
    else                       return s[15:0];
  endfunction

endpackage

// File: rtl/echo_delay_unit_ram.sv
// Single-port delay-line RAM: synchronous write, registered read-before-write,
// no reset so it maps onto block RAM.
module echo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_delay_unit.sv
// Echo stage: y[n] = sat(x[n] + g*y[n-D]) with a circular delay line,
// one sample per accept through a fixed CLR/IDLE/RD/WAIT/MIX/WR sequence.
module echo_delay_unit
  import echo_pkg::*;
#(
  parameter int DATA_W = echo_pkg::DATA_W,
  parameter int ADDR_W = 12,
  parameter int GAIN_W = echo_pkg::GAIN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic        [ADDR_W-1:0] delay_len,
  input  logic        [GAIN_W-1:0] gain,
  input  logic                     bypass,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_sample,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PW = DATA_W + GAIN_W + 1;

  logic [2:0]               state;
  logic [ADDR_W-1:0]        wr_ptr, clr_addr, d_q, ram_addr;
  logic signed [DATA_W-1:0] x_q;
  logic [GAIN_W-1:0]        g_q;
  logic                     byp_q;

  logic                     ram_we;
  logic [DATA_W-1:0]        ram_wdata, ram_rdata;

  logic signed [PW-1:0]     echo_ext, gain_ext, prod;
  logic signed [DATA_W:0]   echo_term;
  logic signed [DATA_W+1:0] sum;
  logic signed [DATA_W-1:0] y;

  echo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Read address is held through RD and WAIT so rdata is still the echo in MIX.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = wr_ptr - d_q;
    ram_wdata = out_sample;
    case (state)
      CLR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = '0;
      end
      WR: begin
        ram_we   = 1'b1;
        ram_addr = wr_ptr;
      end
      default: ;
    endcase
  end

  // Signed echo times unsigned gain; taking bits above GAIN_W is a floor shift.
  always_comb begin
    echo_ext  = {{(GAIN_W+1){ram_rdata[DATA_W-1]}}, ram_rdata};
    gain_ext  = {{(DATA_W+1){1'b0}}, g_q};
    prod      = echo_ext * gain_ext;
    echo_term = (byp_q || d_q == '0) ? '0 : prod[PW-1:GAIN_W];
    sum       = {{2{x_q[DATA_W-1]}}, x_q} + {echo_term[DATA_W], echo_term};
    y         = saturate(sum);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLR;
      wr_ptr     <= '0;
      clr_addr   <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      overrun    <= 1'b0;
      x_q        <= '0;
      d_q        <= '0;
      g_q        <= '0;
      byp_q      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        CLR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) state <= IDLE;
        end
        IDLE: begin
          if (in_valid) begin
            x_q   <= in_sample;
            d_q   <= delay_len;
            g_q   <= gain;
            byp_q <= bypass;
            state <= RD;
          end
        end
        RD:   state <= WAIT;
        WAIT: state <= MIX;
        MIX: begin
          out_sample <= y;
          out_valid  <= 1'b1;
          state      <= WR;
        end
        WR: begin
          wr_ptr <= wr_ptr + 1'b1;
          state  <= IDLE;
        end
        default: state <= CLR;
      endcase
    end
  end

endmodule
